pio_pattern_sequencer: RTL and testbench

- Avalon-MM bridge that autonomously plays a programmable pattern table into a downstream output PIO (6-bit LED-style out_port, data register at word address 0, no waitrequest).
- CPU programs the table, step period, length and loop mode through a CSR slave; the block's master port then issues timed single-cycle writes to the PIO.
- Sits between the Nios II data master and the PIO slave in the Qsys system.

---
 rtl/pio_pattern_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_pio_pattern_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_pattern_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pio_pattern_sequencer
//  Purpose  : Avalon-MM bridge that plays a CPU-programmed pattern table into
//             a downstream output PIO with a programmable step period, length
//             and loop mode. CSR slave for programming, master for PIO writes.
//  Revision : 1.0  initial release
// ============================================================================
module pio_pattern_sequencer #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata
);

    localparam int         IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [9:0] C_DEPTH = 10'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               run_q, run_d;
    logic               loop_q, loop_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [IW-1:0]      index_q, index_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [8:0]         length_q, length_d;
    logic [IW-1:0]      tindex_q, tindex_d;
    logic [DATA_W-1:0]  pat_q [DEPTH];
    logic               m_cs_q, m_cs_d;
    logic [DATA_W-1:0]  m_data_q, m_data_d;

    logic               w_csr_wr, w_wr_ctrl, w_wr_tdata;
    logic [CNT_W-1:0]   w_period_eff;
    logic [9:0]         w_len_eff, w_next_idx;
    logic               w_advance;
    logic               w_unused_wdata;

    assign w_csr_wr     = s_chipselect & ~s_write_n;
    assign w_wr_ctrl    = w_csr_wr && (s_address == 3'd0);
    assign w_wr_tdata   = w_csr_wr && (s_address == 3'd5);
    assign w_period_eff = (period_q == '0) ? CNT_W'(1) : period_q;
    assign w_next_idx   = 10'(index_q) + 10'd1;
    assign w_unused_wdata = ^s_writedata;

    // Effective sequence length: LENGTH clamped into 1..DEPTH
    always_comb begin
        w_len_eff = {1'b0, length_q};
        if (length_q == 9'd0) begin
            w_len_eff = 10'd1;
        end else if ({1'b0, length_q} > C_DEPTH) begin
            w_len_eff = C_DEPTH;
        end
    end

    // Sequencer next state; CTRL writes override the FSM (abort wins)
    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        loop_d    = loop_q;
        busy_d    = busy_q;
        done_d    = done_q;
        index_d   = index_q;
        cnt_d     = cnt_q;
        w_advance = 1'b0;
        case (state_q)
            ST_IDLE: ;
            ST_WRITE: begin
                cnt_d = w_period_eff - CNT_W'(1);
                if (period_q > CNT_W'(1)) state_d = ST_WAIT;
                else                      w_advance = 1'b1;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) w_advance = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (w_advance) begin
            if (w_next_idx < w_len_eff) begin
                index_d = index_q + IW'(1);
                state_d = ST_WRITE;
            end else if (loop_q) begin
                index_d = '0;
                state_d = ST_WRITE;
            end else begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                run_d   = 1'b0;
                state_d = ST_IDLE;
            end
        end
        if (w_wr_ctrl) begin
            loop_d = s_writedata[1];
            done_d = 1'b0;
            if (!s_writedata[0]) begin
                run_d   = 1'b0;
                busy_d  = 1'b0;
                index_d = index_q;
                state_d = ST_IDLE;
            end else if (state_q == ST_IDLE) begin
                run_d   = 1'b1;
                busy_d  = 1'b1;
                index_d = '0;
                state_d = ST_WRITE;
            end
        end
    end

    // Configuration registers
    always_comb begin
        period_d = period_q;
        length_d = length_q;
        tindex_d = tindex_q;
        if (w_csr_wr) begin
            case (s_address)
                3'd2:    period_d = s_writedata[CNT_W-1:0];
                3'd3:    length_d = s_writedata[8:0];
                3'd4:    tindex_d = s_writedata[IW-1:0];
                default: ;
            endcase
        end
    end

    // Master outputs for the coming cycle; a same-cycle table write to the
    // fetched entry is forwarded so it is seen by this fetch
    always_comb begin
        m_cs_d   = (state_d == ST_WRITE);
        m_data_d = m_data_q;
        if (state_d == ST_WRITE) begin
            if (w_wr_tdata && (tindex_q == index_d)) m_data_d = s_writedata[DATA_W-1:0];
            else                                     m_data_d = pat_q[index_d];
        end
    end

    // Control, status and configuration state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            run_q    <= 1'b0;
            loop_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            index_q  <= '0;
            cnt_q    <= '0;
            period_q <= CNT_W'(1);
            length_q <= 9'(DEPTH);
            tindex_q <= '0;
            m_cs_q   <= 1'b0;
            m_data_q <= '0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            loop_q   <= loop_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            index_q  <= index_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            length_q <= length_d;
            tindex_q <= tindex_d;
            m_cs_q   <= m_cs_d;
            m_data_q <= m_data_d;
        end
    end

    // Pattern table storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) pat_q[i] <= '0;
        end else if (w_wr_tdata) begin
            pat_q[tindex_q] <= s_writedata[DATA_W-1:0];
        end
    end

    // CSR read mux, zero wait states
    always_comb begin
        s_readdata = '0;
        case (s_address)
            3'd0: s_readdata[1:0] = {loop_q, run_q};
            3'd1: begin
                s_readdata[1:0]    = {done_q, busy_q};
                s_readdata[8 +: IW] = index_q;
            end
            3'd2: s_readdata[CNT_W-1:0]  = period_q;
            3'd3: s_readdata[8:0]        = length_q;
            3'd4: s_readdata[IW-1:0]     = tindex_q;
            3'd5: s_readdata[DATA_W-1:0] = pat_q[tindex_q];
            default: ;
        endcase
    end

    assign m_address    = 2'b00;
    assign m_chipselect = m_cs_q;
    assign m_write_n    = ~m_cs_q;
    assign m_writedata  = 32'(m_data_q);

endmodule
`default_nettype wire

// File: tb/tb_pio_pattern_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pio_pattern_sequencer
//  Purpose  : Self-checking bench: behavioural model of the pattern player,
//             directed scenarios with literal expectations, random traffic.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pio_pattern_sequencer;
    localparam int DATA_W = 6, DEPTH = 8, CNT_W = 24;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic [2:0]  s_address = '0;
    logic        s_chipselect = 1'b0, s_write_n = 1'b1;
    logic [31:0] s_writedata = '0, s_readdata;
    logic [1:0]  m_address;
    logic        m_chipselect, m_write_n;
    logic [31:0] m_writedata;

    pio_pattern_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_address(s_address), .s_chipselect(s_chipselect), .s_write_n(s_write_n),
        .s_writedata(s_writedata), .s_readdata(s_readdata),
        .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
        .m_writedata(m_writedata)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0, cyc = 0;
    logic [31:0] last_rd;
    int strobe_cyc[$];
    int strobe_dat[$];

    // Behavioural model: countdown = cycles until the next PIO strobe
    bit md_run, md_loop, md_busy, md_done;
    int md_period, md_length, md_tindex, md_idx, md_cd, md_last;
    int md_tbl[DEPTH];

    function automatic void model_reset();
        md_run = 0; md_loop = 0; md_busy = 0; md_done = 0;
        md_period = 1; md_length = DEPTH; md_tindex = 0; md_idx = 0; md_cd = 0; md_last = 0;
        for (int i = 0; i < DEPTH; i++) md_tbl[i] = 0;
    endfunction

    function automatic int p_eff();
        return (md_period < 1) ? 1 : md_period;
    endfunction

    function automatic int l_eff();
        if (md_length < 1) return 1;
        if (md_length > DEPTH) return DEPTH;
        return md_length;
    endfunction

    function automatic logic [31:0] model_rd(input logic [2:0] a);
        logic [31:0] r;
        int v;
        r = '0;
        case (a)
            3'd0: begin r[0] = md_run; r[1] = md_loop; end
            3'd1: begin r[0] = md_busy; r[1] = md_done; v = md_idx; r[15:8] = v[7:0]; end
            3'd2: begin v = md_period; r[23:0] = v[23:0]; end
            3'd3: begin v = md_length; r[8:0] = v[8:0]; end
            3'd4: begin v = md_tindex; r[2:0] = v[2:0]; end
            3'd5: begin v = md_tbl[md_tindex]; r[5:0] = v[5:0]; end
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic void advance();
        if (md_idx + 1 < l_eff())  md_idx = md_idx + 1;
        else if (md_loop)          md_idx = 0;
        else begin md_done = 1; md_busy = 0; md_run = 0; end
    endfunction

    function automatic void model_clock(input bit cs, input bit wr_n, input logic [2:0] a,
                                        input logic [31:0] wd);
        bit b0;
        int idx0;
        b0 = md_busy; idx0 = md_idx;
        if (md_busy) begin
            if (md_cd == 0) begin
                md_last = md_tbl[md_idx];
                if (p_eff() > 1) md_cd = p_eff() - 1;
                else             advance();
            end else begin
                md_cd = md_cd - 1;
                if (md_cd == 0) advance();
            end
        end
        if (cs && !wr_n) begin
            case (a)
                3'd0: begin
                    md_loop = wd[1]; md_done = 0;
                    if (!wd[0]) begin md_run = 0; md_busy = 0; md_idx = idx0; end
                    else if (!b0) begin md_run = 1; md_busy = 1; md_idx = 0; md_cd = 0; end
                end
                3'd2: md_period = int'(wd[23:0]);
                3'd3: md_length = int'(wd[8:0]);
                3'd4: md_tindex = int'(wd[2:0]);
                3'd5: md_tbl[md_tindex] = int'(wd[5:0]);
                default: ;
            endcase
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle compare of every DUT output against the model
    task automatic compare_outputs();
        bit exp_strobe;
        exp_strobe = md_busy && (md_cd == 0);
        check("m_chipselect", 32'(m_chipselect), 32'(exp_strobe));
        check("m_write_n",    32'(m_write_n),    32'(!exp_strobe));
        check("m_address",    32'(m_address),    32'd0);
        check("m_writedata",  m_writedata, 32'(exp_strobe ? md_tbl[md_idx] : md_last));
        check("s_readdata",   s_readdata,  model_rd(s_address));
    endtask

    task automatic step(input bit cs, input bit wr_n, input logic [2:0] a, input logic [31:0] wd);
        @(negedge clk);
        s_chipselect = cs; s_write_n = wr_n; s_address = a; s_writedata = wd;
        #2;
        compare_outputs();
        last_rd = s_readdata;
        if (m_chipselect && !m_write_n) begin
            strobe_cyc.push_back(cyc);
            strobe_dat.push_back(int'(m_writedata));
        end
        @(posedge clk);
        model_clock(cs, wr_n, a, wd);
        cyc++;
    endtask

    task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
        step(1'b1, 1'b0, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 3'($urandom_range(0, 7)), $urandom);
    endtask

    task automatic read(input logic [2:0] a);
        step(1'b0, 1'b1, a, 32'd0);
    endtask

    // Asynchronous reset pulse in the middle of a clock phase
    task automatic reset_pulse();
        @(negedge clk);
        s_chipselect = 1'b0; s_write_n = 1'b1;
        #3 reset_n = 1'b0;
        #1;
        check("rst_m_cs",   32'(m_chipselect), 32'd0);
        check("rst_m_wr_n", 32'(m_write_n),    32'd1);
        check("rst_m_data", m_writedata,       32'd0);
        s_address = 3'd1; #1 check("rst_status", s_readdata, 32'd0);
        s_address = 3'd5; #1 check("rst_tdata",  s_readdata, 32'd0);
        s_address = 3'd0; #1 check("rst_ctrl",   s_readdata, 32'd0);
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_no_strobe", 32'(m_chipselect), 32'd0);
        end
        reset_n = 1'b1;
        @(posedge clk);
    endtask

    initial begin
        int c0, base, n;
        bit found;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        // Reset values
        read(3'd2); check("rst_period", last_rd, 32'd1);
        read(3'd3); check("rst_length", last_rd, 32'd8);
        read(3'd1); check("rst_status0", last_rd, 32'd0);

        // One-shot, P=4, three entries
        csr_write(4, 0); csr_write(5, 32'h01);
        csr_write(4, 1); csr_write(5, 32'h02);
        csr_write(4, 2); csr_write(5, 32'h04);
        csr_write(3, 3); csr_write(2, 4);
        base = strobe_cyc.size(); c0 = cyc;
        csr_write(0, 32'h1);
        idle(14);
        check("os_count", 32'(strobe_cyc.size() - base), 32'd3);
        if (strobe_cyc.size() - base >= 3) begin
            check("os_t0", 32'(strobe_cyc[base]   - c0), 32'd1);
            check("os_t1", 32'(strobe_cyc[base+1] - c0), 32'd5);
            check("os_t2", 32'(strobe_cyc[base+2] - c0), 32'd9);
            check("os_d0", 32'(strobe_dat[base]),   32'h01);
            check("os_d1", 32'(strobe_dat[base+1]), 32'h02);
            check("os_d2", 32'(strobe_dat[base+2]), 32'h04);
        end
        read(3'd1); check("os_status", last_rd, 32'h0202);
        read(3'd0); check("os_ctrl",   last_rd, 32'h0);

        // Loop with P=1
        csr_write(3, 2); csr_write(2, 0);
        base = strobe_cyc.size(); c0 = cyc;
        csr_write(0, 32'h3);
        idle(6);
        check("lp_count", 32'(strobe_cyc.size() - base), 32'd6);
        for (int k = 0; k < 4 && base + k < strobe_cyc.size(); k++) begin
            check("lp_time", 32'(strobe_cyc[base+k] - c0), 32'(k + 1));
            check("lp_data", 32'(strobe_dat[base+k]), (k % 2) ? 32'h02 : 32'h01);
        end
        read(3'd1); check("lp_busy", 32'(last_rd[0]), 32'd1);

        // Abort in a WAIT cycle
        csr_write(2, 4);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (md_busy && md_cd >= 2) found = 1;
            else idle(1);
        end
        check("ab_reach_wait", 32'(found), 32'd1);
        csr_write(0, 32'h0);
        n = strobe_cyc.size();
        idle(12);
        check("ab_no_strobe", 32'(strobe_cyc.size()), 32'(n));
        read(3'd1); check("ab_status", 32'(last_rd[1:0]), 32'd0);

        // LENGTH=0 -> single strobe of table[0]
        csr_write(3, 0); csr_write(2, 1);
        base = strobe_cyc.size();
        csr_write(0, 32'h1);
        idle(6);
        check("l0_count", 32'(strobe_cyc.size() - base), 32'd1);
        if (strobe_cyc.size() > base) check("l0_data", 32'(strobe_dat[base]), 32'h01);
        read(3'd1); check("l0_status", last_rd, 32'h2);

        // LENGTH=20 clamps to DEPTH
        csr_write(3, 20);
        base = strobe_cyc.size();
        csr_write(0, 32'h1);
        idle(12);
        check("l20_count", 32'(strobe_cyc.size() - base), 32'd8);
        read(3'd1); check("l20_status", last_rd, 32'h0702);

        // Live edits while running with P=10
        csr_write(4, 0); csr_write(5, 32'h11);
        csr_write(4, 1); csr_write(5, 32'h22);
        csr_write(3, 3); csr_write(2, 10);
        base = strobe_cyc.size(); c0 = cyc;
        csr_write(0, 32'h1);
        idle(3);
        csr_write(4, 1); csr_write(5, 32'h3F); csr_write(2, 2);
        idle(12);
        check("le_count", 32'(strobe_cyc.size() - base), 32'd3);
        if (strobe_cyc.size() - base >= 3) begin
            check("le_d0", 32'(strobe_dat[base]),   32'h11);
            check("le_d1", 32'(strobe_dat[base+1]), 32'h3F);
            check("le_t1", 32'(strobe_cyc[base+1] - c0), 32'd11);
            check("le_gap", 32'(strobe_cyc[base+2] - strobe_cyc[base+1]), 32'd2);
        end

        // Reset mid-run
        csr_write(2, 3); csr_write(3, 8); csr_write(0, 32'h3);
        idle(5);
        reset_pulse();
        read(3'd3); check("post_rst_len", last_rd, 32'd8);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (i == 1500) reset_pulse();
            if (r < 3)       csr_write(0, ($urandom_range(0, 9) < 7) ? (32'h1 | 32'($urandom_range(0, 1) << 1))
                                                                     : 32'($urandom_range(0, 3)));
            else if (r < 8)  csr_write(2, 32'($urandom_range(0, 5)));
            else if (r < 11) csr_write(3, 32'($urandom_range(0, 12)));
            else if (r < 16) csr_write(4, $urandom);
            else if (r < 24) csr_write(5, $urandom);
            else if (r < 27) csr_write(3'($urandom_range(6, 7)), $urandom);
            else if (r < 30) step(1'b0, 1'b0, 3'($urandom_range(0, 7)), $urandom);
            else             idle(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
